data_mem_resp: RTL
==================

Name: data_mem_resp

Overview:
- Data-memory responder for the memory-stage data port.
- Accepts chip-enable, write-enable, byte-select, address and write data from the memory stage, and stores words in an internal word-organised array with big-endian byte lanes.
- Returns read data after a fixed, parameterised number of wait cycles.
- Requests a pipeline stall while a read is outstanding, and flags malformed accesses.

Parameters:
- ADDR_WIDTH, 10, word-index width; array depth = 2^ADDR_WIDTH words.
- RD_WAIT, 2, stall cycles per read. Legal range 1..15.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  reset, asynchronous, active-low.
- mem_ce_i  input  1  access request (chip enable).
- mem_we_i  input  1  1 = write, 0 = read.
- mem_addr_i  input  32  byte address; word index = mem_addr_i[ADDR_WIDTH+1:2].
- mem_sel_i  input  4  byte lanes; sel[3] = bits 31:24 … sel[0] = bits 7:0.
- mem_data_i  input  32  write data, already lane-replicated by the requester.
- mem_data_o  output  32  read data (registered).
- mem_stall_o  output  1  stall request to pipeline control.
- err_o  output  1  malformed-access flag.

Behaviour:
- Reset (rst low, asynchronous):
  - state = IDLE, wait counter = 0, mem_data_o = 0.
  - mem_stall_o = 0 and err_o = 0 while rst is low.
  - Array contents are not cleared.
- Address decode:
  - Upper address bits above ADDR_WIDTH+1 are ignored (aliasing).
  - addr[1:0] is ignored; lane choice comes only from sel.
- Writes (mem_ce_i = 1, mem_we_i = 1, state IDLE):
  - Zero wait; mem_stall_o = 0.
  - At the rising edge, each lane with sel[k] = 1 is written from mem_data_i[8k+7:8k]; other lanes are unchanged.
- States: IDLE, WAIT, DONE. The wait counter is 4 bits.
- IDLE:
  - On a read (ce = 1, we = 0): mem_stall_o = 1 combinationally in the same cycle.
  - If RD_WAIT = 1: capture array[word] into mem_data_o at the edge and go to DONE.
  - Otherwise: load counter with RD_WAIT-1 and go to WAIT.
- WAIT:
  - mem_stall_o = 1 while ce = 1.
  - Counter decrements each cycle.
  - When the counter equals 1: capture array[word] at the current address into mem_data_o and go to DONE.
- DONE:
  - mem_stall_o = 0; mem_data_o is valid; the pipeline advances at the end of this cycle.
  - Next state is IDLE unconditionally; the request present during DONE is not re-serviced.
- Timing: stall is high for exactly RD_WAIT cycles per read; data is valid in cycle T+RD_WAIT, where T is the first request cycle.
- Abort: mem_ce_i = 0 in WAIT deasserts mem_stall_o combinationally, returns to IDLE at the next edge, and leaves mem_data_o unchanged.
- mem_data_o holds its last captured value outside DONE.
- err_o is combinational: 1 when mem_ce_i = 1 and mem_sel_i = 4'b0000, i.e. the requester's misaligned halfword case.
  - A write with err_o = 1 modifies nothing.
  - A read with err_o = 1 is still serviced normally and returns the full word.
- Read-after-write: a write committed at edge E is visible to any read capture at or after edge E+1.
- Reset mid-WAIT: immediate IDLE, stall drops asynchronously, and no capture occurs.

Test Plan (RD_WAIT = 2, ADDR_WIDTH = 10):
1. Reset: hold rst low 3 cycles with ce = 1, we = 0 → mem_data_o = 0, mem_stall_o = 0, err_o = 0. Release rst → stall rises on the first cycle of the read.
2. Word write/read: write addr 0x10, sel 1111, data 0x11223344 (no stall); then read 0x10 → stall high exactly 2 cycles, mem_data_o = 0x11223344 in the 3rd cycle with stall = 0.
3. Byte lanes:
   - SB addr 0x11, sel 0100, data 0xAAAAAAAA, then read 0x10 → 0x11AA3344.
   - SH addr 0x12, sel 0011, data 0xBEEFBEEF, then read 0x10 → 0x11AABEEF.
4. Alias and error:
   - Read 0x1010 → 0x11AABEEF (same word index 4).
   - Write sel 0000, addr 0x10, data 0 → err_o = 1 that cycle, then read 0x10 still returns 0x11AABEEF.
5. Abort: start a read, drop ce in the first WAIT cycle → stall 0 in that same cycle, mem_data_o unchanged. A following read takes the full 2 stall cycles.
6. Reset mid-read: assert rst low between clock edges during WAIT → stall 0 immediately, mem_data_o = 0. After release, back-to-back reads to 0x10 and 0x14 (0x14 previously written 0xCAFEF00D) each stall 2 cycles and return correct data.

Source files
------------

// File: rtl/data_mem_if.sv
// data_mem_if: memory-stage data port between the pipeline (master) and the data memory (slave).
interface data_mem_if;
   logic        ce;
   logic        we;
   logic [31:0] addr;
   logic [3:0]  sel;
   logic [31:0] wdata;
   logic [31:0] rdata;
   logic        stall;
   logic        err;
   modport master (output ce, we, addr, sel, wdata, input rdata, stall, err);
   modport slave  (input ce, we, addr, sel, wdata, output rdata, stall, err);
endinterface

// File: rtl/data_mem_resp.sv
// data_mem_resp: word-organised data memory with zero-wait writes and fixed-latency stalled reads.
module data_mem_resp #(
   parameter int ADDR_WIDTH = 10,
   parameter int RD_WAIT    = 2
) (
   input logic        clk,
   input logic        rst,
   data_mem_if.slave  bus
);
   typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;
   state_t                  state, state_nx;
   logic [3:0]              cnt, cnt_nx;
   logic [31:0]             rdata;
   logic                    cap, stall;
   logic [ADDR_WIDTH-1:0]   idx;
   logic [31:0]             mem [2**ADDR_WIDTH];
   assign idx       = bus.addr[ADDR_WIDTH+1:2];
   assign bus.rdata = rdata;
   // Outputs are forced low during reset, even with a read request held on the bus.
   assign bus.stall = rst & stall;
   assign bus.err   = rst & bus.ce & ~|bus.sel;
   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      cap      = 1'b0;
      stall    = 1'b0;
      case (state)
         IDLE: if (bus.ce && !bus.we) begin
            stall = 1'b1;
            if (RD_WAIT == 1) begin
               cap      = 1'b1;
               state_nx = DONE;
            end else begin
               cnt_nx   = 4'(RD_WAIT - 1);
               state_nx = WAIT;
            end
         end
         WAIT: if (!bus.ce) state_nx = IDLE;
         else begin
            stall  = 1'b1;
            cnt_nx = cnt - 4'd1;
            if (cnt == 4'd1) begin
               cap      = 1'b1;
               state_nx = DONE;
            end
         end
         default: state_nx = IDLE;
      endcase
   end
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         state <= IDLE;
         cnt   <= '0;
         rdata <= '0;
      end else begin
         state <= state_nx;
         cnt   <= cnt_nx;
         if (cap) rdata <= mem[idx];
      end
   // An all-zero sel writes no lane, so malformed writes leave the array untouched.
   always_ff @(posedge clk)
      if (rst && state == IDLE && bus.ce && bus.we)
         for (int k = 0; k < 4; k++)
            if (bus.sel[k]) mem[idx][8*k+:8] <= bus.wdata[8*k+:8];
endmodule
